spi_register_bridge: RTL and testbench
======================================

// Module: spi_register_bridge
// PURPOSE
//  Byte-protocol engine directly downstream of the SPI peripheral, in the FPGA clock domain.
//  Consumes received bytes (rx_dv/rx_byte) and decodes a command byte {rw, addr[6:0]}.
//  Turns the command into burst writes or reads on a simple register bus, with auto-increment.
//  Feeds response bytes back to the peripheral (tx_dv/tx_byte) in time for the next SPI byte.
// PARAMETERS
//  ADDR_W       7      register address width, 1..7; cmd bits [6:ADDR_W] ignored
//  STATUS_BYTE  8'hA5  byte preloaded for shifting out during every command byte
// PORTS
//  i_clk        in   1       FPGA clock (>= 4x SPI clock); single clock domain
//  i_reset_n    in   1       asynchronous, active-low reset
//  i_spi_cs_n   in   1       raw SPI chip select; asynchronous, synchronised internally
//  i_rx_dv      in   1       1-cycle pulse: i_rx_byte valid
//  i_rx_byte    in   8       received byte; valid only while i_rx_dv=1
//  o_tx_dv      out  1       1-cycle pulse: load o_tx_byte into the peripheral
//  o_tx_byte    out  8       next byte to serialise on CIPO
//  o_reg_wr_en  out  1       1-cycle write strobe
//  o_reg_rd_en  out  1       1-cycle read strobe
//  o_reg_addr   out  ADDR_W  register address for wr/rd strobe
//  o_reg_wdata  out  8       write data, valid with o_reg_wr_en
//  i_reg_rdata  in   8       read data, valid exactly 1 cycle after o_reg_rd_en
//  o_overrun    out  1       sticky: byte arrived while a read fetch was in flight
// BEHAVIOUR
//  Reset (i_reset_n=0, async): all outputs 0, state S_CMD, address 0, cs sync flops = 1.
//  - First cycle after release: o_tx_dv=1, o_tx_byte=STATUS_BYTE.
//  CS: 2-flop synchroniser. Rising edge of synced cs_n forces S_CMD from any state.
//  - Same rising edge: reloads STATUS_BYTE (o_tx_dv pulse). Address is kept, not cleared.
//  All outputs are registered. N = cycle in which i_rx_dv=1.
//  S_CMD, on rx_dv: addr <= rx_byte[ADDR_W-1:0].
//  - rx_byte[7]=0 -> S_WR.
//  - rx_byte[7]=1 -> S_RD_REQ.
//  S_WR, on rx_dv:
//  - N+1: o_reg_wr_en=1, o_reg_addr=addr, o_reg_wdata=rx_byte.
//  - addr <= addr+1 after the strobe; stay in S_WR (burst).
//  S_RD_REQ: o_reg_rd_en=1 with o_reg_addr=addr at N+1 (one cycle after entry) -> S_RD_LOAD.
//  S_RD_LOAD: capture i_reg_rdata; o_tx_dv=1, o_tx_byte=rdata at N+3.
//  - addr <= addr+1 -> S_RD.
//  S_RD, on rx_dv (dummy byte, value ignored) -> S_RD_REQ (prefetch next address).
//  Latency: o_tx_dv <= 3 cycles after i_rx_dv; meets SPI next-byte deadline at 4x clock.
//  Address arithmetic: modulo 2^ADDR_W; addr max+1 wraps to 0 in both bursts.
//  rx_dv in S_RD_REQ/S_RD_LOAD: byte dropped, o_overrun <= 1; cleared only by reset.
//  rx_dv in the same cycle as a cs rising edge: cs wins; byte dropped, no strobe.
//  - o_overrun is not set in this case.
//  Write burst: o_tx_byte is not reloaded, so the peripheral repeats its last loaded byte.
//  Never assert o_reg_wr_en and o_reg_rd_en in the same cycle.
// STRUCTURE
//  spi_bridge_pkg: state encoding (S_CMD,S_WR,S_RD_REQ,S_RD_LOAD,S_RD).
//  - Also: CMD_RW_BIT=7 and default STATUS_BYTE localparams.
//  Sub-module spi_cs_sync: 2-flop synchroniser (reset to 1) + rising-edge detect pulse.
//  Remainder: one FSM always block, address counter, registered output stage.
// TESTING
//  1 Write burst: cs low; bytes 0x05,0x11,0x22 -> wr (addr 5,0x11),(6,0x22); each at N+1.
//  2 Read burst: regs 0x10=0xAB, 0x11=0xCD; bytes 0x90,0x00,0x00.
//    -> rd_en addr 0x10 then 0x11; tx_byte 0xAB then 0xCD, each within 3 cycles of rx_dv.
//  3 Wrap: write cmd 0x7F, data 0x01,0x02 -> wr at addr 0x7F then 0x00.
//    Read cmd 0xFF -> rd_en at 0x7F then 0x00.
//  4 CS abort: cs_n high after read cmd 0x90 -> state S_CMD, tx_dv with 0xA5.
//    Next byte 0x03 is treated as a write command.
//  5 Overrun: rx_dv on 2 consecutive cycles in S_RD -> o_overrun=1, second byte ignored.
//    o_overrun stays set across cs toggles.
//  6 Reset mid-burst: i_reset_n low during S_WR -> outputs 0 immediately.
//    After release: tx_dv with 0xA5, state S_CMD.

Source files
------------

// File: rtl/spi_register_bridge_pkg.sv
// Shared definitions for the SPI byte-protocol to register-bus bridge:
// FSM state encoding, command-byte layout and the default status byte.
package spi_bridge_pkg;

    typedef enum logic [2:0] {
        S_CMD,
        S_WR,
        S_RD_REQ,
        S_RD_LOAD,
        S_RD
    } state_t;

    localparam int         CMD_RW_BIT          = 7;
    localparam logic [7:0] DEFAULT_STATUS_BYTE = 8'hA5;

endpackage

// File: rtl/spi_register_bridge_if.sv
// Byte stream (to/from the SPI peripheral) and register bus, named from the
// bridge's point of view. The bridge uses master; the peripheral/register side uses slave.
interface spi_register_bridge_if #(
    parameter int ADDR_W = 7
);
    logic              i_rx_dv;
    logic [7:0]        i_rx_byte;
    logic              o_tx_dv;
    logic [7:0]        o_tx_byte;
    logic              o_reg_wr_en;
    logic              o_reg_rd_en;
    logic [ADDR_W-1:0] o_reg_addr;
    logic [7:0]        o_reg_wdata;
    logic [7:0]        i_reg_rdata;
    logic              o_overrun;

    modport master (
        input  i_rx_dv, i_rx_byte, i_reg_rdata,
        output o_tx_dv, o_tx_byte, o_reg_wr_en, o_reg_rd_en,
               o_reg_addr, o_reg_wdata, o_overrun
    );

    modport slave (
        output i_rx_dv, i_rx_byte, i_reg_rdata,
        input  o_tx_dv, o_tx_byte, o_reg_wr_en, o_reg_rd_en,
               o_reg_addr, o_reg_wdata, o_overrun
    );
endinterface

// File: rtl/spi_register_bridge_cs_sync.sv
// Two-flop synchroniser for the raw SPI chip select plus a one-cycle pulse
// on the rising edge of the synchronised level (end of transaction).
module spi_cs_sync (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_cs_n,
    output logic o_cs_rise
);
    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    // Reset to 1 (deselected) so leaving reset never looks like a cs edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make each stage sample the previous
            // stage's old value, which is what turns these three lines into a shift chain.
            r_meta   <= i_cs_n;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign o_cs_rise = r_sync & ~r_sync_d;

endmodule

// File: rtl/spi_register_bridge.sv
// Decodes {rw, addr} command bytes from the SPI peripheral into auto-incrementing
// burst writes/reads on a simple register bus and returns read data as tx bytes.
module spi_register_bridge
    import spi_bridge_pkg::*;
#(
    parameter int         ADDR_W      = 7,
    parameter logic [7:0] STATUS_BYTE = DEFAULT_STATUS_BYTE
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_spi_cs_n,
    spi_register_bridge_if.master bus
);
    state_t            r_state;
    logic              r_init;
    logic [ADDR_W-1:0] r_addr;
    logic              r_tx_dv;
    logic [7:0]        r_tx_byte;
    logic              r_wr_en;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_reg_addr;
    logic [7:0]        r_wdata;
    logic              r_overrun;

    state_t            w_state_nx;
    logic [ADDR_W-1:0] w_addr_nx;
    logic              w_tx_dv_nx;
    logic [7:0]        w_tx_byte_nx;
    logic              w_wr_en_nx;
    logic              w_rd_en_nx;
    logic [ADDR_W-1:0] w_reg_addr_nx;
    logic [7:0]        w_wdata_nx;
    logic              w_overrun_nx;
    logic              w_cs_rise;
    logic [ADDR_W-1:0] w_cmd_addr;

    spi_cs_sync u_cs_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_cs_n    (i_spi_cs_n),
        .o_cs_rise (w_cs_rise)
    );

    assign w_cmd_addr = bus.i_rx_byte[ADDR_W-1:0];

    always_comb begin
        // NOTE: every signal gets a default before the branches; a path that
        // leaves one unassigned would infer a latch.
        w_state_nx    = r_state;
        w_addr_nx     = r_addr;
        w_tx_dv_nx    = 1'b0;
        w_tx_byte_nx  = r_tx_byte;
        w_wr_en_nx    = 1'b0;
        w_rd_en_nx    = 1'b0;
        w_reg_addr_nx = r_reg_addr;
        w_wdata_nx    = r_wdata;
        w_overrun_nx  = r_overrun;

        if (r_init) begin
            w_tx_dv_nx   = 1'b1;
            w_tx_byte_nx = STATUS_BYTE;
        end else if (w_cs_rise) begin
            // End of transaction beats any byte arriving in the same cycle.
            w_state_nx   = S_CMD;
            w_tx_dv_nx   = 1'b1;
            w_tx_byte_nx = STATUS_BYTE;
        end else begin
            unique case (r_state)
                S_CMD: begin
                    if (bus.i_rx_dv) begin
                        w_addr_nx = w_cmd_addr;
                        if (bus.i_rx_byte[CMD_RW_BIT]) begin
                            // Read strobe leaves with the command so data is back by N+3.
                            w_state_nx    = S_RD_REQ;
                            w_rd_en_nx    = 1'b1;
                            w_reg_addr_nx = w_cmd_addr;
                        end else begin
                            w_state_nx = S_WR;
                        end
                    end
                end
                S_WR: begin
                    if (bus.i_rx_dv) begin
                        w_wr_en_nx    = 1'b1;
                        w_reg_addr_nx = r_addr;
                        w_wdata_nx    = bus.i_rx_byte;
                        w_addr_nx     = r_addr + 1'b1;
                    end
                end
                S_RD_REQ: begin
                    w_state_nx = S_RD_LOAD;
                    if (bus.i_rx_dv) w_overrun_nx = 1'b1;
                end
                S_RD_LOAD: begin
                    w_state_nx   = S_RD;
                    w_tx_dv_nx   = 1'b1;
                    w_tx_byte_nx = bus.i_reg_rdata;
                    w_addr_nx    = r_addr + 1'b1;
                    if (bus.i_rx_dv) w_overrun_nx = 1'b1;
                end
                S_RD: begin
                    if (bus.i_rx_dv) begin
                        w_state_nx    = S_RD_REQ;
                        w_rd_en_nx    = 1'b1;
                        w_reg_addr_nx = r_addr;
                    end
                end
                default: w_state_nx = S_CMD;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_CMD;
            r_init     <= 1'b1;
            r_addr     <= '0;
            r_tx_dv    <= 1'b0;
            r_tx_byte  <= '0;
            r_wr_en    <= 1'b0;
            r_rd_en    <= 1'b0;
            r_reg_addr <= '0;
            r_wdata    <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_init     <= 1'b0;
            r_addr     <= w_addr_nx;
            r_tx_dv    <= w_tx_dv_nx;
            r_tx_byte  <= w_tx_byte_nx;
            r_wr_en    <= w_wr_en_nx;
            r_rd_en    <= w_rd_en_nx;
            r_reg_addr <= w_reg_addr_nx;
            r_wdata    <= w_wdata_nx;
            r_overrun  <= w_overrun_nx;
        end
    end

    assign bus.o_tx_dv     = r_tx_dv;
    assign bus.o_tx_byte   = r_tx_byte;
    assign bus.o_reg_wr_en = r_wr_en;
    assign bus.o_reg_rd_en = r_rd_en;
    assign bus.o_reg_addr  = r_reg_addr;
    assign bus.o_reg_wdata = r_wdata;
    assign bus.o_overrun   = r_overrun;

endmodule

// File: tb/tb_spi_register_bridge.sv
// Directed bench for spi_register_bridge: write/read bursts, address wrap,
// cs abort, overrun and reset mid-burst, with hand-computed expectations.
module tb_spi_register_bridge;

    logic clk;
    logic rst_n;
    logic cs_n;
    logic [7:0] mem [0:127];
    int checks = 0;
    int errors = 0;

    spi_register_bridge_if #(.ADDR_W(7)) bus ();

    spi_register_bridge #(.ADDR_W(7), .STATUS_BYTE(8'hA5)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_spi_cs_n (cs_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: read data valid exactly one cycle after the strobe.
    always @(posedge clk) begin
        if (bus.o_reg_rd_en) bus.i_reg_rdata <= mem[bus.o_reg_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a 1-cycle rx_dv pulse; on return we sit in cycle N+1.
    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_dv   = 1'b1;
        bus.i_rx_byte = b;
        tick();
        bus.i_rx_dv   = 1'b0;
        bus.i_rx_byte = 8'h00;
    endtask

    // Raise cs_n; the reload pulse lands three edges later (2 sync + 1 output register).
    task automatic cs_end(input string tag);
        cs_n = 1'b1;
        tick();
        tick();
        tick();
        check({tag, "_cs_txdv"}, bus.o_tx_dv, 1);
        check({tag, "_cs_txbyte"}, bus.o_tx_byte, 8'hA5);
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[7'h10] = 8'hAB;
        mem[7'h11] = 8'hCD;
        mem[7'h7F] = 8'h5A;
        mem[7'h00] = 8'h3C;
        rst_n         = 1'b0;
        cs_n          = 1'b1;
        bus.i_rx_dv   = 1'b0;
        bus.i_rx_byte = 8'h00;
        tick();
        tick();

        check("rst_txdv", bus.o_tx_dv, 0);
        check("rst_txbyte", bus.o_tx_byte, 0);
        check("rst_wren", bus.o_reg_wr_en, 0);
        check("rst_rden", bus.o_reg_rd_en, 0);
        check("rst_addr", bus.o_reg_addr, 0);
        check("rst_overrun", bus.o_overrun, 0);

        rst_n = 1'b1;
        tick();
        check("boot_txdv", bus.o_tx_dv, 1);
        check("boot_txbyte", bus.o_tx_byte, 8'hA5);
        tick();
        check("boot_txdv_pulse", bus.o_tx_dv, 0);

        // 1: write burst
        cs_start();
        send_byte(8'h05);
        check("t1_cmd_wren", bus.o_reg_wr_en, 0);
        send_byte(8'h11);
        check("t1_w0_wren", bus.o_reg_wr_en, 1);
        check("t1_w0_addr", bus.o_reg_addr, 7'h05);
        check("t1_w0_data", bus.o_reg_wdata, 8'h11);
        check("t1_w0_rden", bus.o_reg_rd_en, 0);
        send_byte(8'h22);
        check("t1_w1_wren", bus.o_reg_wr_en, 1);
        check("t1_w1_addr", bus.o_reg_addr, 7'h06);
        check("t1_w1_data", bus.o_reg_wdata, 8'h22);
        check("t1_w1_txdv", bus.o_tx_dv, 0);
        tick();
        check("t1_idle_wren", bus.o_reg_wr_en, 0);
        cs_end("t1");

        // 2: read burst
        cs_start();
        send_byte(8'h90);
        check("t2_r0_rden", bus.o_reg_rd_en, 1);
        check("t2_r0_addr", bus.o_reg_addr, 7'h10);
        tick();
        check("t2_r0_early_txdv", bus.o_tx_dv, 0);
        tick();
        check("t2_r0_txdv", bus.o_tx_dv, 1);
        check("t2_r0_txbyte", bus.o_tx_byte, 8'hAB);
        tick();
        send_byte(8'h00);
        check("t2_r1_rden", bus.o_reg_rd_en, 1);
        check("t2_r1_addr", bus.o_reg_addr, 7'h11);
        tick();
        tick();
        check("t2_r1_txdv", bus.o_tx_dv, 1);
        check("t2_r1_txbyte", bus.o_tx_byte, 8'hCD);
        tick();
        send_byte(8'h00);
        check("t2_r2_addr", bus.o_reg_addr, 7'h12);
        check("t2_r2_wren", bus.o_reg_wr_en, 0);
        tick();
        tick();
        check("t2_overrun", bus.o_overrun, 0);
        cs_end("t2");

        // 3: address wrap in both bursts
        cs_start();
        send_byte(8'h7F);
        send_byte(8'h01);
        check("t3_w0_addr", bus.o_reg_addr, 7'h7F);
        check("t3_w0_data", bus.o_reg_wdata, 8'h01);
        send_byte(8'h02);
        check("t3_w1_wren", bus.o_reg_wr_en, 1);
        check("t3_w1_addr", bus.o_reg_addr, 7'h00);
        check("t3_w1_data", bus.o_reg_wdata, 8'h02);
        cs_end("t3w");
        cs_start();
        send_byte(8'hFF);
        check("t3_r0_rden", bus.o_reg_rd_en, 1);
        check("t3_r0_addr", bus.o_reg_addr, 7'h7F);
        tick();
        tick();
        check("t3_r0_txbyte", bus.o_tx_byte, 8'h5A);
        tick();
        send_byte(8'h00);
        check("t3_r1_rden", bus.o_reg_rd_en, 1);
        check("t3_r1_addr", bus.o_reg_addr, 7'h00);
        tick();
        tick();
        check("t3_r1_txbyte", bus.o_tx_byte, 8'h3C);
        cs_end("t3r");

        // 4: cs abort mid-read, next byte is a fresh write command
        cs_start();
        send_byte(8'h90);
        tick();
        tick();
        check("t4_r0_txbyte", bus.o_tx_byte, 8'hAB);
        cs_end("t4");
        cs_start();
        send_byte(8'h03);
        check("t4_cmd_wren", bus.o_reg_wr_en, 0);
        check("t4_cmd_rden", bus.o_reg_rd_en, 0);
        send_byte(8'h44);
        check("t4_w0_wren", bus.o_reg_wr_en, 1);
        check("t4_w0_addr", bus.o_reg_addr, 7'h03);
        check("t4_w0_data", bus.o_reg_wdata, 8'h44);
        // Byte landing in the same cycle as the cs rising-edge pulse is dropped.
        cs_n = 1'b1;
        tick();
        tick();
        send_byte(8'h55);
        check("t4_race_wren", bus.o_reg_wr_en, 0);
        check("t4_race_txdv", bus.o_tx_dv, 1);
        check("t4_race_txbyte", bus.o_tx_byte, 8'hA5);
        check("t4_race_overrun", bus.o_overrun, 0);

        // 5: overrun
        cs_start();
        send_byte(8'h90);
        tick();
        tick();
        tick();
        send_byte(8'h00);
        check("t5_prefetch_addr", bus.o_reg_addr, 7'h11);
        send_byte(8'h77);
        check("t5_overrun_set", bus.o_overrun, 1);
        check("t5_second_rden", bus.o_reg_rd_en, 0);
        check("t5_second_wren", bus.o_reg_wr_en, 0);
        tick();
        check("t5_txbyte", bus.o_tx_byte, 8'hCD);
        tick();
        check("t5_no_extra_rd", bus.o_reg_rd_en, 0);
        cs_end("t5");
        cs_start();
        check("t5_overrun_sticky", bus.o_overrun, 1);

        // 6: reset mid write burst
        send_byte(8'h20);
        send_byte(8'h99);
        check("t6_pre_wren", bus.o_reg_wr_en, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_wren", bus.o_reg_wr_en, 0);
        check("t6_rst_wdata", bus.o_reg_wdata, 0);
        check("t6_rst_addr", bus.o_reg_addr, 0);
        check("t6_rst_overrun", bus.o_overrun, 0);
        check("t6_rst_txbyte", bus.o_tx_byte, 0);
        cs_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_boot_txdv", bus.o_tx_dv, 1);
        check("t6_boot_txbyte", bus.o_tx_byte, 8'hA5);
        cs_start();
        send_byte(8'h85);
        check("t6_cmd_rden", bus.o_reg_rd_en, 1);
        check("t6_cmd_addr", bus.o_reg_addr, 7'h05);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
